// File: rtl/pipe_reg_skid_if.sv
// Valid/ready handshake bundle for pipe_reg_skid: upstream (in_*) and downstream (out_*) sides.
interface pipe_reg_skid_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// Pipeline register stage with 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional back-pressure counter enabled by defining PIPE_REG_SKID_STALL_CNT_EN.
module pipe_reg_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_reg_skid_if.slave       bus,
  output logic [1:0]           occupancy,
  output logic [31:0]          stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_fire, out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = bus.in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the drain path exists
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
    case (state_d)
      S_ONE:   occ_d = 2'd1;
      S_FULL:  occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_q;

`ifdef PIPE_REG_SKID_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating; flush deliberately leaves it untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (bus.in_valid && !in_ready_q && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
